// File: rtl/bp_table_port_ctrl_pkg.sv
// Shared types for the branch-predictor table port: update payload and port state.
// Table geometry below is the widest supported; narrower configurations use the low index bits.
package cva5_types;
    localparam int unsigned BP_MAX_INDEX_W = 9;
    localparam int unsigned BP_WAYS        = 2;
    localparam int unsigned BP_ENTRY_W     = 24;
    localparam int unsigned BP_TARGET_W    = 32;

    typedef struct packed {
        logic [BP_MAX_INDEX_W-1:0] index;
        logic [BP_WAYS-1:0]        way;
        logic                      tgt_we;
        logic [BP_ENTRY_W-1:0]     entry;
        logic [BP_TARGET_W-1:0]    target;
    } bp_update_t;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } bp_port_state_t;

    // Target-table write mask: only the update's way, and only when it carries a target.
    function automatic logic [BP_WAYS-1:0] bp_tgt_mask(input bp_update_t u);
        return u.tgt_we ? u.way : '0;
    endfunction
endpackage

// File: rtl/bp_table_port_ctrl_fifo.sv
// Small power-of-two FIFO of predictor updates with synchronous clear.
module bp_update_fifo
    import cva5_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_push,
    input  bp_update_t i_push_data,
    input  logic       i_pop,
    output bp_update_t o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    bp_update_t     r_mem [DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
endmodule

// File: rtl/bp_table_port_ctrl.sv
// Shared-port sequencer for the branch-predictor tag/target tables: invalidation sweep,
// fetch lookups and queued updates. Optional BP_UPDATE_BYPASS_EN writes idle-cycle updates directly.
module bp_table_port_ctrl
    import cva5_types::*;
#(
    parameter  int unsigned ENTRIES    = 512,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned INDEX_W    = $clog2(ENTRIES),
    localparam int unsigned WAYS       = BP_WAYS,
    localparam int unsigned ENTRY_W    = BP_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               predict_en,
    input  logic               fetch_req,
    input  logic [INDEX_W-1:0] fetch_index,
    output logic               fetch_grant,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [WAYS-1:0]    upd_way,
    input  logic               upd_tgt_we,
    input  logic [ENTRY_W-1:0] upd_entry,
    input  logic [31:0]        upd_target,
    output logic               ram_en,
    output logic [INDEX_W-1:0] ram_addr,
    output logic [WAYS-1:0]    ram_tag_we,
    output logic [WAYS-1:0]    ram_tgt_we,
    output logic [ENTRY_W-1:0] ram_entry,
    output logic [31:0]        ram_target
);
    bp_port_state_t     r_state, w_state_nxt;
    logic [INDEX_W-1:0] r_sweep_cnt, w_sweep_cnt_nxt;
    logic               r_flush_done, w_flush_done_nxt;
    logic               w_push, w_pop, w_wr;
    logic               w_fifo_full, w_fifo_empty;
    bp_update_t         w_head, w_upd, w_wr_data;

    assign w_upd = '{index:  BP_MAX_INDEX_W'(upd_index),
                     way:    upd_way,
                     tgt_we: upd_tgt_we,
                     entry:  upd_entry,
                     target: upd_target};

    bp_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_clear     (flush_req),
        .i_push      (w_push),
        .i_push_data (w_upd),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SWEEP;
            r_sweep_cnt  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_cnt  <= w_sweep_cnt_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    assign flush_done = r_flush_done;

    // Port arbitration and next state.
    always_comb begin
        w_state_nxt      = r_state;
        w_sweep_cnt_nxt  = r_sweep_cnt;
        w_flush_done_nxt = 1'b0;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_wr             = 1'b0;
        w_wr_data        = w_head;
        predict_en       = 1'b0;
        fetch_grant      = 1'b0;
        upd_ready        = 1'b0;
        ram_en           = 1'b0;
        ram_addr         = '0;
        ram_tag_we       = '0;
        ram_tgt_we       = '0;
        ram_entry        = '0;
        ram_target       = '0;

        case (r_state)
            SWEEP: begin
                ram_en          = 1'b1;
                ram_addr        = r_sweep_cnt;
                ram_tag_we      = '1;
                upd_ready       = 1'b1;
                w_sweep_cnt_nxt = r_sweep_cnt + INDEX_W'(1);
                if (r_sweep_cnt == INDEX_W'(ENTRIES - 1)) begin
                    w_state_nxt      = READY;
                    w_flush_done_nxt = !flush_req;
                end
            end
            READY: begin
                predict_en = 1'b1;
                upd_ready  = !w_fifo_full;
                w_push     = upd_valid && !w_fifo_full;
                if (w_fifo_full && fetch_req) begin
                    w_wr  = 1'b1;
                    w_pop = 1'b1;
                end else if (fetch_req) begin
                    ram_en      = 1'b1;
                    ram_addr    = fetch_index;
                    fetch_grant = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_wr  = 1'b1;
                    w_pop = 1'b1;
                end
`ifdef BP_UPDATE_BYPASS_EN
                else if (upd_valid) begin
                    w_wr      = 1'b1;
                    w_wr_data = w_upd;
                    w_push    = 1'b0;
                end
`endif
            end
            default: w_state_nxt = SWEEP;
        endcase

        if (w_wr) begin
            ram_en     = 1'b1;
            ram_addr   = INDEX_W'(w_wr_data.index);
            ram_tag_we = w_wr_data.way;
            ram_tgt_we = bp_tgt_mask(w_wr_data);
            ram_entry  = w_wr_data.entry;
            ram_target = w_wr_data.target;
        end

        // Flush discards the queue (and any same-cycle enqueue) but lets this cycle's access finish.
        if (flush_req) begin
            w_state_nxt     = SWEEP;
            w_sweep_cnt_nxt = '0;
            w_push          = 1'b0;
        end
    end
endmodule

// File: doc/bp_table_port_ctrl.md
Name: bp_table_port_ctrl

Overview:
- Sequences the single shared port of the branch-predictor tag/target tables.
- Arbitrates between three sources:
  - fetch lookups (reads),
  - execute-stage update writes, queued in a small FIFO,
  - an invalidation sweep that clears every entry after reset and on a flush request.
- Gates prediction use while the tables are not yet coherent.
- Sits between the fetch stage, branch-resolution logic and the predictor RAMs.

Parameters:
- ENTRIES, 512, table rows per way (power of two); INDEX_W = $clog2(ENTRIES).
- WAYS, 2, number of ways.
- ENTRY_W, 24, bits of one tag-table entry; bit ENTRY_W-1 is the valid bit.
- FIFO_DEPTH, 4, update queue depth (power of two, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- flush_req  in  1  request full table invalidation (e.g. fence.i).
- flush_done  out  1  one-cycle pulse when a sweep completes.
- predict_en  out  1  fetch may use predictions.
- fetch_req  in  1  lookup request this cycle.
- fetch_index  in  INDEX_W  lookup row.
- fetch_grant  out  1  lookup performed this cycle.
- upd_valid  in  1  update offered.
- upd_ready  out  1  update accepted.
- upd_index  in  INDEX_W  row to write.
- upd_way  in  WAYS  one-hot way to write.
- upd_tgt_we  in  1  also write the target.
- upd_entry  in  ENTRY_W  tag-table data.
- upd_target  in  32  target-table data.
- ram_en  out  1  port enable.
- ram_addr  out  INDEX_W  port row.
- ram_tag_we  out  WAYS  per-way tag write enable.
- ram_tgt_we  out  WAYS  per-way target write enable.
- ram_entry  out  ENTRY_W  tag write data.
- ram_target  out  32  target write data.

Behaviour:
- States: SWEEP, READY. Reset (rst low, asynchronous) enters SWEEP with sweep_cnt=0 and the FIFO empty.
- Reset values of registered outputs: flush_done=0.
- While reset is held, all outputs are at their SWEEP values with sweep_cnt=0. This includes ram_tag_we=all ones (a write to row 0).
- SWEEP:
  - Each cycle: ram_en=1, ram_addr=sweep_cnt, ram_tag_we=all ones, ram_tgt_we=0, ram_entry=0.
  - sweep_cnt increments each cycle.
  - fetch_grant=0 and predict_en=0.
  - upd_ready=1; accepted updates are dropped (they are stale).
  - After the write of row ENTRIES-1, the next state is READY and flush_done pulses for one cycle, in the first READY cycle.
  - A sweep therefore lasts exactly ENTRIES cycles.
- READY: predict_en=1 and upd_ready=!fifo_full. Port priority per cycle:
  1. FIFO full and fetch_req: steal the port, write the head, fetch_grant=0.
  2. fetch_req: read at fetch_index, fetch_grant=1, no write.
  3. FIFO non-empty: write the head.
  4. Otherwise ram_en=0.
- Head write:
  - ram_addr=head.index, ram_tag_we=head.way.
  - ram_tgt_we = head.way when head.tgt_we, else 0.
  - Data comes from the head; the FIFO pops in the same cycle.
- Enqueue and dequeue in the same cycle are legal, but upd_ready is computed from the current fullness only (no full-pass-through).
- FIFO ordering is strict. Two updates to the same row land in order, and the last write wins.
- flush_req:
  - Sampled in any state; the next state is SWEEP with sweep_cnt=0.
  - The FIFO is cleared, and any update accepted in the same cycle is dropped.
  - The current cycle's port operation still completes.
  - In SWEEP, flush_req restarts the count.
  - flush_done is suppressed if flush_req coincides with the final sweep row.
- A lookup may return data older than a queued update. This is permitted, since predictions are advisory.

Optional Feature:
- Macro: BP_UPDATE_BYPASS_EN.
- Defined: in READY with the FIFO empty, no fetch_req and upd_valid=1, the update is written to the port in the same cycle and not enqueued (zero-cycle latency).
- Undefined: every update passes through the FIFO, so the minimum write latency is 1 cycle after acceptance.

Decomposition:
- Shared package (cva5_types):
  - bp_update_t packed struct {index, way, tgt_we, entry, target},
  - bp_port_state_t enum {SWEEP, READY}.
- Sub-module bp_update_fifo: parameterised on DEPTH and holding bp_update_t, with push/pop/full/empty and a synchronous clear.

Test Plan:
- ENTRIES=16, release reset: ram_tag_we=11 with entry 0 on rows 0..15 over 16 cycles; flush_done=1 in cycle 17; predict_en rises in the same cycle.
- READY, fetch_req held high, 4 updates offered: 4 accepted, then upd_ready=0. The next cycle shows fetch_grant=0 and the first update's row written (steal), and upd_ready rises again.
- fetch_req=0, 3 queued updates: written in order, one per cycle. upd_tgt_we=0 gives ram_tgt_we=00 for that update.
- 2 updates queued, flush_req pulsed: FIFO discarded, SWEEP restarts at row 0, and neither queued update appears on the port.
- flush_req pulsed at sweep row 9: counter restarts at 0, giving 16 more sweep cycles before flush_done.
- With BP_UPDATE_BYPASS_EN defined, FIFO empty, idle fetch, update to row 5 way 01: ram_tag_we=01 and ram_addr=5 in the same cycle.
